atcbmc300_us_rdata_ctrl: RTL and testbench
==========================================

Name: atcbmc300_us_rdata_ctrl

Overview:
- Master-side (upstream) read-data controller of the bus matrix; one instance per master port.
- Collects read-data beats offered by all slave-side read-data controllers and selects, by round-robin, the slave whose pending beat carries this master's port index.
- Locks the grant for a whole burst, up to and including the RLAST beat.
- Drives the master R channel and publishes the granted slave index (rsid) plus the master's rready, which every slave-side controller compares against its own self_id.

Parameters:
- DATA_WIDTH, 64: read data width.
- ID_WIDTH, 4: master-visible ID width. Internal rid is ID_WIDTH+4 wide; rid[3:0] is the master port index.
- NUM_SLV, 32: slave slots, index 0..NUM_SLV-1. Slot 0 is the default slave. Unused slots tie rvalid low.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- self_id  input  4  this master port index
- slv_rvalid  input  NUM_SLV  per-slave rvalid
- slv_rid  input  NUM_SLV*(ID_WIDTH+4)  per-slave rid; slot s occupies bits [s*(ID_WIDTH+4) +: ID_WIDTH+4]
- slv_read_data  input  NUM_SLV*(DATA_WIDTH+3)  per-slave {rresp[1:0], rlast, rdata}
- mst_rvalid  output  1  R valid to master
- mst_rdata  output  DATA_WIDTH  R data
- mst_rresp  output  2  R resp
- mst_rlast  output  1  R last
- mst_rid  output  ID_WIDTH  granted rid[ID_WIDTH+3:4]
- mst_rready  input  1  R ready from master
- mst_rsid  output  5  granted slave index, broadcast to slaves
- us_rready  output  1  qualified ready, broadcast to slaves

Behaviour:
- Request: req[s] = slv_rvalid[s] & (slv_rid_s[3:0] == self_id). Combinational.
- FSM has two states, IDLE and BURST. Registers: state, grant[4:0], last_grant[4:0].
- IDLE:
  - mst_rvalid=0, us_rready=0.
  - If |req: grant <= first requesting slot at or after (last_grant+1) mod NUM_SLV, wrapping; last_grant <= same value; next state BURST.
  - Arbitration costs one bubble cycle; no beat is transferred in IDLE.
- BURST:
  - g = grant.
  - mst_rvalid = req[g]. Data, resp, last and rid are muxed from slot g.
  - us_rready = mst_rready.
  - mst_rsid = grant at all times (registered, glitch-free).
  - A beat transfers when mst_rvalid & mst_rready.
  - Transfer with rlast=1: next state IDLE.
  - Otherwise stay in BURST; the grant cannot be pre-empted by other requesters.
- If slot g drops rvalid or presents another master's index mid-burst:
  - mst_rvalid=0; hold BURST and grant; wait.
  - us_rready still follows mst_rready. This is safe because the slave side gates its ready with the rid master index.
- mst_rvalid never depends on mst_rready. Output data is combinational from the slave inputs (zero-latency pass-through in BURST).
- last_grant updates only on a new grant. The pointer wraps from NUM_SLV-1 to 0.
- Out-of-range index (grant >= NUM_SLV) is unreachable; the mux returns zeros if it occurs.
- Simultaneous RLAST handshake and new requests: return to IDLE first; the next grant occurs the following cycle.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, grant=0, last_grant=NUM_SLV-1 so that slot 0 has first priority.
  - Outputs: mst_rvalid=0, us_rready=0, mst_rsid=0, mst_rdata/rresp/rlast/rid=0 (IDLE drives zeros).
  - No partial-burst state is retained.

Test Plan:
- Single burst: slot 3 offers rid={4'h5,4'h2}, self_id=2, 4 beats, mst_rready=1.
  - Cycle 1: grant=3, mst_rsid=3.
  - Beats on cycles 2-5 with mst_rid=5, rdata in order, mst_rlast only on beat 4.
  - Cycle 6: IDLE.
- Round-robin: slots 0, 7 and 31 request simultaneously from reset, each with 1-beat bursts.
  - Grant order must be 0, 7, 31, 0.
  - One IDLE cycle between bursts.
- Filtering: slot 5 offers rid[3:0]=1, self_id=2.
  - No grant; mst_rvalid=0 and us_rready=0 indefinitely.
- Backpressure: 2-beat burst from slot 9; mst_rready held 0 for 3 cycles, then 1.
  - mst_rvalid stays 1 and data stays stable while stalled.
  - us_rready=0 during the stall.
  - Burst completes; slot 4 requesting meanwhile is not granted until after RLAST.
- Mid-burst valid gap: slot 2 drops rvalid for 2 cycles between beats 1 and 2.
  - mst_rvalid=0 during the gap; grant stays 2.
  - Beat 2 is delivered afterwards.
- Reset mid-burst: assert aresetn=0 during beat 2 of 4.
  - Outputs go to zero immediately.
  - After release, state=IDLE and slot 0 has highest priority.

Source files
------------

// File: rtl/atcbmc300_us_rdata_ctrl.sv
// Master-side read-data controller: round-robin selects the slave whose pending R beat
// targets this master, locks the grant for the whole burst and passes R through.
module atcbmc300_us_rdata_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned NUM_SLV    = 32
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [3:0]                         self_id,
    input  logic [NUM_SLV-1:0]                 slv_rvalid,
    input  logic [NUM_SLV*(ID_WIDTH+4)-1:0]    slv_rid,
    input  logic [NUM_SLV*(DATA_WIDTH+3)-1:0]  slv_read_data,
    output logic                               mst_rvalid,
    output logic [DATA_WIDTH-1:0]              mst_rdata,
    output logic [1:0]                         mst_rresp,
    output logic                               mst_rlast,
    output logic [ID_WIDTH-1:0]                mst_rid,
    input  logic                               mst_rready,
    output logic [4:0]                         mst_rsid,
    output logic                               us_rready
);

    localparam int unsigned RID_W = ID_WIDTH + 4;
    localparam int unsigned RD_W  = DATA_WIDTH + 3;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t      r_state;
    logic [4:0]  r_grant;
    logic [4:0]  r_last_grant;

    logic [NUM_SLV-1:0]  w_req;
    logic [RD_W-1:0]     w_slot_arr [NUM_SLV];
    logic [ID_WIDTH-1:0] w_rid_arr  [NUM_SLV];
    logic                w_found;
    logic [4:0]          w_next;
    logic [5:0]          w_sum;
    logic                w_in_range;
    logic                w_gvalid;
    logic [RD_W-1:0]     w_sel;
    logic [ID_WIDTH-1:0] w_sel_rid;

    // Per-slot request: valid beat whose rid carries this master's port index
    for (genvar s = 0; s < int'(NUM_SLV); s++) begin : g_slot
        assign w_req[s]      = slv_rvalid[s] & (slv_rid[s*RID_W +: 4] == self_id);
        assign w_slot_arr[s] = slv_read_data[s*RD_W +: RD_W];
        assign w_rid_arr[s]  = slv_rid[s*RID_W + 4 +: ID_WIDTH];
    end

    // Round-robin search starting one past the previous grant, wrapping at NUM_SLV
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_sum   = '0;
        for (int k = 1; k <= int'(NUM_SLV); k++) begin
            w_sum = 6'(r_last_grant) + 6'(k);
            if (w_sum >= 6'(NUM_SLV)) begin
                w_sum = w_sum - 6'(NUM_SLV);
            end
            if (!w_found && w_req[w_sum[4:0]]) begin
                w_found = 1'b1;
                w_next  = w_sum[4:0];
            end
        end
    end

    // Granted-slot mux; an out-of-range grant yields zeros
    always_comb begin
        w_in_range = (32'(r_grant) < NUM_SLV);
        w_gvalid   = 1'b0;
        w_sel      = '0;
        w_sel_rid  = '0;
        if (w_in_range) begin
            w_gvalid  = w_req[r_grant];
            w_sel     = w_slot_arr[r_grant];
            w_sel_rid = w_rid_arr[r_grant];
        end
    end

    always_comb begin
        mst_rvalid = 1'b0;
        mst_rdata  = '0;
        mst_rresp  = '0;
        mst_rlast  = 1'b0;
        mst_rid    = '0;
        us_rready  = 1'b0;
        if (r_state == ST_BURST) begin
            mst_rvalid = w_gvalid;
            mst_rdata  = w_sel[DATA_WIDTH-1:0];
            mst_rlast  = w_sel[DATA_WIDTH];
            mst_rresp  = w_sel[DATA_WIDTH+2:DATA_WIDTH+1];
            mst_rid    = w_sel_rid;
            us_rready  = mst_rready;
        end
    end

    assign mst_rsid = r_grant;

    // Grant is taken in IDLE (one bubble) and held until the RLAST handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= 5'(NUM_SLV - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_next;
                        r_last_grant <= w_next;
                        r_state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (mst_rvalid && mst_rready && mst_rlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atcbmc300_us_rdata_ctrl.sv
// Bench for atcbmc300_us_rdata_ctrl: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level arbitration model.
module tb_atcbmc300_us_rdata_ctrl;

    localparam int unsigned NS   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned IW   = 4;
    localparam int          NONE = 20;

    logic              clk;
    logic              rst_n;
    logic [3:0]        self_id;
    logic [NS-1:0]     slv_rvalid;
    logic [NS*8-1:0]   slv_rid;
    logic [NS*67-1:0]  slv_read_data;
    logic              mst_rvalid;
    logic [DW-1:0]     mst_rdata;
    logic [1:0]        mst_rresp;
    logic              mst_rlast;
    logic [IW-1:0]     mst_rid;
    logic              mst_rready;
    logic [4:0]        mst_rsid;
    logic              us_rready;

    logic        cur_valid [NS];
    logic [7:0]  cur_rid   [NS];
    logic [63:0] cur_data  [NS];
    logic        cur_last  [NS];
    logic [1:0]  cur_resp  [NS];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       name;
        int          a_slot;
        logic        a_valid;
        logic [7:0]  a_rid;
        logic [63:0] a_data;
        logic        a_last;
        int          b_slot;
        logic        b_valid;
        logic [7:0]  b_rid;
        logic [63:0] b_data;
        logic        b_last;
        logic        ready;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_last;
        logic [3:0]  e_rid;
        logic [4:0]  e_rsid;
        logic        e_usr;
    } vec_t;

    typedef struct {
        logic [7:0]  rid;
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    vec_t  tbl [$];
    beat_t q [NS][$];

    atcbmc300_us_rdata_ctrl #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_SLV(NS)) dut (
        .aclk          (clk),
        .aresetn       (rst_n),
        .self_id       (self_id),
        .slv_rvalid    (slv_rvalid),
        .slv_rid       (slv_rid),
        .slv_read_data (slv_read_data),
        .mst_rvalid    (mst_rvalid),
        .mst_rdata     (mst_rdata),
        .mst_rresp     (mst_rresp),
        .mst_rlast     (mst_rlast),
        .mst_rid       (mst_rid),
        .mst_rready    (mst_rready),
        .mst_rsid      (mst_rsid),
        .us_rready     (us_rready)
    );

    for (genvar s = 0; s < int'(NS); s++) begin : g_drv
        assign slv_rvalid[s]              = cur_valid[s];
        assign slv_rid[s*8 +: 8]          = cur_rid[s];
        assign slv_read_data[s*67 +: 67]  = {cur_resp[s], cur_last[s], cur_data[s]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] pk(input logic v, input logic l, input logic [1:0] r,
                                       input logic [3:0] id, input logic [4:0] sid, input logic u);
        return 64'({v, l, r, id, sid, u});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic v, input logic [63:0] d, input logic l,
                              input logic [1:0] r, input logic [3:0] id, input logic [4:0] sid,
                              input logic u);
        check({name, "_ctrl"}, pk(mst_rvalid, mst_rlast, mst_rresp, mst_rid, mst_rsid, us_rready),
              pk(v, l, r, id, sid, u));
        check({name, "_data"}, mst_rdata, d);
    endtask

    task automatic clear_slots();
        for (int s = 0; s < int'(NS); s++) begin
            cur_valid[s] = 1'b0;
            cur_rid[s]   = '0;
            cur_data[s]  = '0;
            cur_last[s]  = 1'b0;
            cur_resp[s]  = '0;
        end
    endtask

    task automatic set_slot(input int s, input logic v, input logic [7:0] rid,
                            input logic [63:0] d, input logic l, input logic [1:0] r);
        cur_valid[s] = v;
        cur_rid[s]   = rid;
        cur_data[s]  = d;
        cur_last[s]  = l;
        cur_resp[s]  = r;
    endtask

    // Reset with a live own-index request on slot 0 to show outputs stay quiet
    task automatic do_reset(input logic [3:0] sid, input bit chk);
        rst_n      = 1'b0;
        self_id    = sid;
        mst_rready = 1'b1;
        clear_slots();
        set_slot(0, 1'b1, {4'h3, sid}, 64'h1234, 1'b1, 2'b01);
        @(posedge clk);
        @(negedge clk);
        if (chk) check_outs("reset", 1'b0, 64'h0, 1'b0, 2'b00, 4'h0, 5'd0, 1'b0);
        clear_slots();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t v(input string nm, input int as, input logic av, input logic [7:0] ar,
                               input logic [63:0] ad, input logic al, input int bs, input logic bv,
                               input logic [7:0] br, input logic [63:0] bd, input logic bl,
                               input logic rdy, input logic ev, input logic [63:0] ed,
                               input logic el, input logic [3:0] eid, input logic [4:0] esid,
                               input logic eu);
        vec_t t;
        t.name = nm; t.a_slot = as; t.a_valid = av; t.a_rid = ar; t.a_data = ad; t.a_last = al;
        t.b_slot = bs; t.b_valid = bv; t.b_rid = br; t.b_data = bd; t.b_last = bl;
        t.ready = rdy; t.e_valid = ev; t.e_data = ed; t.e_last = el; t.e_rid = eid;
        t.e_rsid = esid; t.e_usr = eu;
        return t;
    endfunction

    task automatic build_table();
        // single 4-beat burst from slot 3, rid {5,2}
        tbl.push_back(v("sb_idle", 3, 1, 8'h52, 64'hD0, 0, NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v("sb_b1",   3, 1, 8'h52, 64'hD0, 0, NONE, 0, 0, 0, 0, 1, 1, 64'hD0, 0, 5, 3, 1));
        tbl.push_back(v("sb_b2",   3, 1, 8'h52, 64'hD1, 0, NONE, 0, 0, 0, 0, 1, 1, 64'hD1, 0, 5, 3, 1));
        tbl.push_back(v("sb_b3",   3, 1, 8'h52, 64'hD2, 0, NONE, 0, 0, 0, 0, 1, 1, 64'hD2, 0, 5, 3, 1));
        tbl.push_back(v("sb_b4",   3, 1, 8'h52, 64'hD3, 1, NONE, 0, 0, 0, 0, 1, 1, 64'hD3, 1, 5, 3, 1));
        tbl.push_back(v("sb_done", NONE, 0, 0, 0, 0,    NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 3, 0));
        // foreign master index on slot 5 is never granted
        for (int i = 0; i < 3; i++)
            tbl.push_back(v("flt", 5, 1, 8'h31, 64'hEE, 1, NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0));
        // backpressure on slot 9 while slot 4 waits for the burst to end
        tbl.push_back(v("bp_idle", 9, 1, 8'hA2, 64'hE0, 0, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v("bp_stall", 9, 1, 8'hA2, 64'hE0, 0, 4, 1, 8'h72, 64'hB4, 1, 0,
                            1, 64'hE0, 0, 4'hA, 9, 0));
        tbl.push_back(v("bp_go",    9, 1, 8'hA2, 64'hE0, 0, 4, 1, 8'h72, 64'hB4, 1, 1, 1, 64'hE0, 0, 4'hA, 9, 1));
        tbl.push_back(v("bp_last",  9, 1, 8'hA2, 64'hE1, 1, 4, 1, 8'h72, 64'hB4, 1, 1, 1, 64'hE1, 1, 4'hA, 9, 1));
        tbl.push_back(v("bp_gap",   NONE, 0, 0, 0, 0,   4, 1, 8'h72, 64'hB4, 1, 1, 0, 0,       0, 0,    9, 0));
        tbl.push_back(v("bp_s4",    NONE, 0, 0, 0, 0,   4, 1, 8'h72, 64'hB4, 1, 1, 1, 64'hB4, 1, 4'h7, 4, 1));
        tbl.push_back(v("bp_end",   NONE, 0, 0, 0, 0,   NONE, 0, 0, 0, 0, 1, 0, 0,             0, 0,    4, 0));
        // valid gap inside a burst from slot 2
        tbl.push_back(v("gp_idle", 2, 1, 8'h12, 64'hF0, 0, NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 4, 0));
        tbl.push_back(v("gp_b1",   2, 1, 8'h12, 64'hF0, 0, NONE, 0, 0, 0, 0, 1, 1, 64'hF0, 0, 1, 2, 1));
        tbl.push_back(v("gp_gap",  2, 0, 8'h00, 64'h00, 0, NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 2, 1));
        tbl.push_back(v("gp_gap",  2, 0, 8'h00, 64'h00, 0, NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 2, 1));
        tbl.push_back(v("gp_b2",   2, 1, 8'h12, 64'hF1, 1, NONE, 0, 0, 0, 0, 1, 1, 64'hF1, 1, 1, 2, 1));
        tbl.push_back(v("gp_end",  NONE, 0, 0, 0, 0,    NONE, 0, 0, 0, 0, 1, 0, 0,      0, 0, 2, 0));
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            clear_slots();
            set_slot(tbl[i].a_slot, tbl[i].a_valid, tbl[i].a_rid, tbl[i].a_data, tbl[i].a_last, 2'b00);
            set_slot(tbl[i].b_slot, tbl[i].b_valid, tbl[i].b_rid, tbl[i].b_data, tbl[i].b_last, 2'b00);
            mst_rready = tbl[i].ready;
            @(negedge clk);
            check_outs(tbl[i].name, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_last, 2'b00,
                       tbl[i].e_rid, tbl[i].e_rsid, tbl[i].e_usr);
        end
    endtask

    task automatic run_round_robin();
        int order [4];
        order = '{0, 7, 31, 0};
        do_reset(4'h2, 1'b0);
        set_slot(0,  1'b1, 8'h12, 64'd0,  1'b1, 2'b00);
        set_slot(7,  1'b1, 8'h12, 64'd7,  1'b1, 2'b00);
        set_slot(31, 1'b1, 8'h12, 64'd31, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("rr_beat", 1'b1, 64'(order[k]), 1'b1, 2'b00, 4'h1, 5'(order[k]), 1'b1);
            @(posedge clk);
            @(negedge clk);
            check_outs("rr_bubble", 1'b0, 64'h0, 1'b0, 2'b00, 4'h0, 5'(order[k]), 1'b0);
        end
    endtask

    task automatic run_reset_mid_burst();
        do_reset(4'h2, 1'b0);
        set_slot(6, 1'b1, 8'h32, 64'h60, 1'b0, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check_outs("rm_b1", 1'b1, 64'h60, 1'b0, 2'b00, 4'h3, 5'd6, 1'b1);
        @(posedge clk);
        #1;
        set_slot(6, 1'b1, 8'h32, 64'h61, 1'b0, 2'b00);
        set_slot(0, 1'b1, 8'h92, 64'hAA, 1'b1, 2'b10);
        @(negedge clk);
        check_outs("rm_b2", 1'b1, 64'h61, 1'b0, 2'b00, 4'h3, 5'd6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rm_async", 1'b0, 64'h0, 1'b0, 2'b00, 4'h0, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("rm_slot0", 1'b1, 64'hAA, 1'b1, 2'b10, 4'h9, 5'd0, 1'b1);
    endtask

    function automatic int pending();
        int n = 0;
        for (int s = 0; s < int'(NS); s++) n += q[s].size();
        return n;
    endfunction

    // Randomized traffic; model: owner slot (-1 when idle) and round-robin pointer
    task automatic run_random();
        int          slots [6];
        logic [3:0]  sid;
        logic [3:0]  foreign;
        int          owner;
        int          ptr;
        int          gnt;
        int          idx;
        int          len;
        logic [3:0]  mi;
        logic [3:0]  hi;
        beat_t       b;
        logic        ev;
        logic        el;
        logic [1:0]  er;
        logic [3:0]  eid;
        logic [63:0] ed;
        logic        eu;
        slots   = '{0, 1, 5, 17, 30, 31};
        sid     = 4'($urandom_range(0, 15));
        foreign = sid + 4'd1;
        foreach (slots[i]) begin
            for (int bu = 0; bu < 6; bu++) begin
                len = $urandom_range(1, 4);
                mi  = ($urandom_range(0, 4) == 0) ? foreign : sid;
                hi  = 4'($urandom_range(0, 15));
                for (int j = 0; j < len; j++) begin
                    b.rid  = {hi, mi};
                    b.data = {$urandom, $urandom};
                    b.last = (j == len - 1);
                    b.resp = 2'($urandom_range(0, 3));
                    q[slots[i]].push_back(b);
                end
            end
        end
        do_reset(sid, 1'b0);
        owner = -1;
        ptr   = int'(NS) - 1;
        gnt   = 0;
        for (int cyc = 0; cyc < 4000 && pending() > 0; cyc++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < int'(NS); s++) begin
                if (q[s].size() > 0 && $urandom_range(0, 9) < 7)
                    set_slot(s, 1'b1, q[s][0].rid, q[s][0].data, q[s][0].last, q[s][0].resp);
                else
                    set_slot(s, 1'b0, 8'h0, 64'h0, 1'b0, 2'b00);
            end
            mst_rready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            ev = 0; el = 0; er = 0; eid = 0; ed = 0; eu = 0;
            if (owner >= 0) begin
                ev  = cur_valid[owner] && (cur_rid[owner][3:0] == sid);
                el  = cur_last[owner];
                er  = cur_resp[owner];
                eid = cur_rid[owner][7:4];
                ed  = cur_data[owner];
                eu  = mst_rready;
            end
            check("rnd_ctrl", pk(mst_rvalid, mst_rlast, mst_rresp, mst_rid, mst_rsid, us_rready),
                  pk(ev, el, er, eid, 5'((owner >= 0) ? owner : gnt), eu));
            check("rnd_data", mst_rdata, ed);
            if (owner >= 0) begin
                if (ev && mst_rready) begin
                    q[owner].delete(0);
                    if (el) begin
                        gnt   = owner;
                        owner = -1;
                    end
                end
            end else begin
                for (int k = 1; k <= int'(NS); k++) begin
                    idx = (ptr + k) % int'(NS);
                    if (cur_valid[idx] && cur_rid[idx][3:0] == sid) begin
                        owner = idx;
                        ptr   = idx;
                        gnt   = idx;
                        break;
                    end
                end
            end
            // beats for other masters are consumed elsewhere at random
            for (int s = 0; s < int'(NS); s++) begin
                if (cur_valid[s] && cur_rid[s][3:0] != sid && $urandom_range(0, 1) == 1)
                    q[s].delete(0);
            end
        end
        check("rnd_drain", 64'(pending()), 64'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        self_id    = 4'h2;
        mst_rready = 1'b0;
        clear_slots();
        build_table();
        do_reset(4'h2, 1'b1);
        run_table();
        run_round_robin();
        run_reset_mid_burst();
        run_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
